// File: rtl/issue_queue_ctrl.sv
// Instruction queue and scheduler between the 64-bit fetch path and two decode slots.
// Define ISSUE_DUAL_EN to enable dual issue; otherwise one instruction pops per cycle.
module issue_queue_ctrl #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_valid,
    input  logic [63:0]                fetch_inst,
    input  logic [31:0]                fetch_pc,
    output logic                       fetch_ready,
    input  logic                       flush,
    input  logic                       issue_stall,
    output logic                       issue0_valid,
    output logic [31:0]                issue0_inst,
    output logic [31:0]                issue0_pc,
    output logic                       issue1_valid,
    output logic [31:0]                issue1_inst,
    output logic [31:0]                issue1_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_nx;
    logic [AW-1:0] tail_nx;
    logic          push;
    logic [CW-1:0] push_n;
    logic [CW-1:0] pop_n;

    assign head_nx      = head + AW'(1);
    assign tail_nx      = tail + AW'(1);
    assign fetch_ready  = (count <= CW'(DEPTH - 2));
    assign push         = fetch_valid && fetch_ready && !flush;
    assign push_n       = fetch_pc[2] ? CW'(1) : CW'(2);

    assign issue0_valid = (count >= CW'(1));
    assign issue0_inst  = mem_inst[head];
    assign issue0_pc    = mem_pc[head];
    assign issue1_inst  = mem_inst[head_nx];
    assign issue1_pc    = mem_pc[head_nx];

`ifdef ISSUE_DUAL_EN
    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == 7'b1100011) || (op == 7'b1101111) || (op == 7'b1100111);
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return (op == 7'b0000011) || (op == 7'b0100011);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return (op == 7'b0110111) || (op == 7'b0010111) || (op == 7'b1101111) ||
               (op == 7'b1100111) || (op == 7'b0000011) || (op == 7'b0010011) ||
               (op == 7'b0110011);
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        return !((op == 7'b0110111) || (op == 7'b0010111) || (op == 7'b1101111));
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == 7'b1100011) || (op == 7'b0100011) || (op == 7'b0110011);
    endfunction

    logic [6:0] op0;
    logic [6:0] op1;
    logic [4:0] rd0;
    logic       wr0;
    logic       raw;
    logic       waw;
    logic       pair_ok;

    always_comb begin
        op0     = issue0_inst[6:0];
        op1     = issue1_inst[6:0];
        rd0     = issue0_inst[11:7];
        wr0     = writes_rd(op0) && (rd0 != 5'd0);
        raw     = wr0 && ((reads_rs1(op1) && (issue1_inst[19:15] == rd0)) ||
                          (reads_rs2(op1) && (issue1_inst[24:20] == rd0)));
        waw     = wr0 && writes_rd(op1) && (issue1_inst[11:7] == rd0);
        pair_ok = !is_ctrl(op0) && (op0 != 7'b1110011) && (op1 != 7'b1110011) &&
                  !(is_mem(op0) && is_mem(op1)) && !raw && !waw;
    end

    assign issue1_valid = (count >= CW'(2)) && pair_ok;
`else
    assign issue1_valid = 1'b0;
`endif

    assign pop_n = (issue_stall || flush) ? '0 : (CW'(issue0_valid) + CW'(issue1_valid));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(push_n);
            end
            head  <= head + AW'(pop_n);
            count <= count + (push ? push_n : '0) - pop_n;
        end
    end

    // Storage is deliberately left out of reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            if (!fetch_pc[2]) begin
                mem_inst[tail]    <= fetch_inst[31:0];
                mem_pc[tail]      <= fetch_pc;
                mem_inst[tail_nx] <= fetch_inst[63:32];
                mem_pc[tail_nx]   <= fetch_pc + 32'd4;
            end else begin
                mem_inst[tail]    <= fetch_inst[63:32];
                mem_pc[tail]      <= fetch_pc;
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// Scoreboard bench for issue_queue_ctrl (DEPTH=8); expectations follow ISSUE_DUAL_EN.
module tb_issue_queue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [63:0] fetch_inst;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        flush;
    logic        issue_stall;
    logic        issue0_valid;
    logic [31:0] issue0_inst;
    logic [31:0] issue0_pc;
    logic        issue1_valid;
    logic [31:0] issue1_inst;
    logic [31:0] issue1_pc;
    logic [3:0]  count;

    int errors = 0;
    int checks = 0;

`ifdef ISSUE_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    typedef struct {
        logic [31:0] i0;
        logic [31:0] p0;
        logic        dual;
        logic [31:0] i1;
        logic [31:0] p1;
    } issue_rec_t;

    issue_rec_t exp_q[$];

    issue_queue_ctrl #(.DEPTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_valid  (fetch_valid),
        .fetch_inst   (fetch_inst),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .flush        (flush),
        .issue_stall  (issue_stall),
        .issue0_valid (issue0_valid),
        .issue0_inst  (issue0_inst),
        .issue0_pc    (issue0_pc),
        .issue1_valid (issue1_valid),
        .issue1_inst  (issue1_inst),
        .issue1_pc    (issue1_pc),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever the head is valid and nothing blocks it.
    always @(negedge clk) begin
        if (!reset && !flush && !issue_stall && issue0_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", issue0_pc, 32'hFFFF_FFFF);
            end else begin
                issue_rec_t r;
                r = exp_q.pop_front();
                chk("slot0_inst", issue0_inst, r.i0);
                chk("slot0_pc", issue0_pc, r.p0);
                chk("slot1_valid", 32'(issue1_valid), 32'(r.dual));
                if (r.dual) begin
                    chk("slot1_inst", issue1_inst, r.i1);
                    chk("slot1_pc", issue1_pc, r.p1);
                end
            end
        end
    end

    task automatic drive_pair(input logic [31:0] pc, input logic [31:0] lo, input logic [31:0] hi);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_inst  = {hi, lo};
        @(posedge clk); #1;
        fetch_valid = 1'b0;
    endtask

    task automatic push_pair(input logic [31:0] pc, input logic [31:0] lo, input logic [31:0] hi,
                             input bit ok);
        issue_rec_t r;
        if (pc[2]) begin
            r = '{hi, pc, 1'b0, 32'h0, 32'h0};
            exp_q.push_back(r);
        end else if (DUAL && ok) begin
            r = '{lo, pc, 1'b1, hi, pc + 32'd4};
            exp_q.push_back(r);
        end else begin
            r = '{lo, pc, 1'b0, 32'h0, 32'h0};
            exp_q.push_back(r);
            r = '{hi, pc + 32'd4, 1'b0, 32'h0, 32'h0};
            exp_q.push_back(r);
        end
        drive_pair(pc, lo, hi);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (count == 4'd0) break;
            @(posedge clk); #1;
        end
        chk("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        fetch_valid = 1'b0;
        fetch_inst  = '0;
        fetch_pc    = '0;
        flush       = 1'b0;
        issue_stall = 1'b0;
        @(posedge clk); #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(fetch_ready), 32'd1);
        chk("rst_v0", 32'(issue0_valid), 32'd0);
        chk("rst_v1", 32'(issue1_valid), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Two independent addis
        push_pair(32'h0, 32'h00100093, 32'h00200113, 1'b1);
        chk("v1_count", 32'(count), 32'd2);
        chk("v1_v0", 32'(issue0_valid), 32'd1);
        chk("v1_v1", 32'(issue1_valid), 32'(DUAL));
        @(posedge clk); #1;
        chk("v1_count_after", 32'(count), DUAL ? 32'd0 : 32'd1);
        drain();

        // RAW hazard
        push_pair(32'h0, 32'h00100093, 32'h001081B3, 1'b0);
        chk("raw_v1", 32'(issue1_valid), 32'd0);
        drain();

        push_pair(32'h10, 32'h00000063, 32'h00100093, 1'b0);   // branch in slot 0
        drain();
        push_pair(32'h20, 32'h0000A083, 32'h0000A103, 1'b0);   // two loads
        drain();
        push_pair(32'h30, 32'h00100293, 32'h00200293, 1'b0);   // WAW on x5
        drain();
        push_pair(32'h40, 32'h00100093, 32'h00000073, 1'b0);   // ecall in slot 1
        drain();
        push_pair(32'h50, 32'h002081B3, 32'h00208233, 1'b1);   // independent adds
        drain();
        push_pair(32'h60, 32'h00000013, 32'h000001B3, 1'b1);   // rd=x0 never hazards
        drain();

        // Misaligned fetch keeps only the upper half
        push_pair(32'h104, 32'hDEADBEEF, 32'h00300193, 1'b0);
        chk("odd_count", 32'(count), 32'd1);
        chk("odd_pc", issue0_pc, 32'h104);
        chk("odd_inst", issue0_inst, 32'h00300193);
        drain();

        // Fill under stall, overflow attempt, flush
        issue_stall = 1'b1;
        for (int k = 0; k < 3; k++) drive_pair(32'h200 + 32'(k * 8), 32'h00100093 + 32'(k), 32'h00200113);
        chk("fill6_count", 32'(count), 32'd6);
        chk("fill6_ready", 32'(fetch_ready), 32'd1);
        drive_pair(32'h218, 32'h00500293, 32'h00600313);
        chk("full_count", 32'(count), 32'd8);
        chk("full_ready", 32'(fetch_ready), 32'd0);
        chk("stall_hold_pc", issue0_pc, 32'h200);
        drive_pair(32'h220, 32'h11111111, 32'h22222222);
        chk("overflow_count", 32'(count), 32'd8);
        chk("overflow_inst", issue0_inst, 32'h00100093);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_v0", 32'(issue0_valid), 32'd0);
        chk("flush_v1", 32'(issue1_valid), 32'd0);
        chk("flush_ready", 32'(fetch_ready), 32'd1);

        // Asynchronous reset mid-operation
        drive_pair(32'h300, 32'h00100093, 32'h00200113);
        chk("pre_rst_count", 32'(count), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_v0", 32'(issue0_valid), 32'd0);
        chk("async_rst_ready", 32'(fetch_ready), 32'd1);
        reset = 1'b0;
        issue_stall = 1'b0;
        @(posedge clk); #1;

        // Post-reset operation still works
        push_pair(32'h400, 32'h00100093, 32'h00200113, 1'b1);
        drain();
        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/issue_queue_ctrl.md
# issue_queue_ctrl

- Instruction queue and dual-issue scheduler between the 64-bit fetch path and the two decode slots of the dual-issue core.
- Accepts aligned instruction pairs from fetch and buffers them in a circular queue.
- Each cycle it presents one or two oldest instructions to decoder slots 0 and 1.
- Slot 1 is held back when RV32I pairing rules detect a hazard with slot 0.

## Interface

Parameters:
- `DEPTH`, default 8: queue capacity in 32-bit instructions. Power of two, ≥4.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears queue
- `fetch_valid`  in  1  fetch pair valid this cycle
- `fetch_inst`  in  64  [31:0] instruction at `fetch_pc & ~4`, [63:32] at `(fetch_pc & ~4)+4`
- `fetch_pc`  in  32  fetch address; bit 2 set means lower half is discarded
- `fetch_ready`  out  1  queue can accept a pair (free entries ≥2)
- `flush`  in  1  redirect: discard all queued and incoming instructions
- `issue_stall`  in  1  back end cannot accept; no pop
- `issue0_valid`  out  1  slot 0 holds an instruction
- `issue0_inst`  out  32  slot 0 instruction
- `issue0_pc`  out  32  slot 0 PC
- `issue1_valid`  out  1  slot 1 issues together with slot 0
- `issue1_inst`  out  32  slot 1 instruction
- `issue1_pc`  out  32  slot 1 PC
- `count`  out  log2(DEPTH)+1  current occupancy

## Operation

Storage:
- Circular buffer of {inst, pc} entries.
- Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Separate occupancy counter.

Push:
- A push occurs when `fetch_valid && fetch_ready && !flush`.
- If `fetch_pc[2]==0`, enqueue both halves in order: lower at PC `fetch_pc`, then upper at PC `fetch_pc+4`. `count += 2`.
- If `fetch_pc[2]==1`, enqueue only the upper half with PC `fetch_pc`. `count += 1`.
- `fetch_ready = (DEPTH - count) >= 2`. It uses the current count only; a same-cycle pop is not anticipated.

Issue:
- `issue0_*` always shows the head entry.
- `issue1_*` always shows the head+1 entry.
- `issue0_valid = count>=1`.
- `issue1_valid = count>=2 && pair_ok`.

Pop:
- Pops occur on an edge when `!issue_stall && !flush`.
- Pop count is `issue0_valid + issue1_valid`.
- Push and pop may occur in the same cycle. Count updates by the net change.

Opcode classes, from `inst[6:0]`:
- CTRL: 1100011 (BRANCH), 1101111 (JAL), 1100111 (JALR)
- MEM: 0000011 (LOAD), 0100011 (STORE)
- SYS: 1110011

Register usage:
- rd is written by LUI, AUIPC, JAL, JALR, LOAD, OP-IMM (0010011), OP (0110011).
- rs1 is read by all classes except LUI, AUIPC, JAL.
- rs2 is read by BRANCH, STORE, OP.

`pair_ok` is true only if all of the following hold:
- Slot 0 is not CTRL.
- Neither slot is SYS.
- Not both slots are MEM.
- RAW: if slot 0 writes a nonzero rd, slot 1 reads no register equal to that rd.
- WAW: slot 0 and slot 1 do not both write the same nonzero rd.

Flush:
- Head, tail and count go to 0 on the next edge.
- Same-cycle push and pop are both suppressed.

## Timing

- Reset (async): head, tail and count are 0. All `issue*_valid` drop combinationally to 0. `fetch_ready` is 1.
- Storage is not cleared. `issue*_inst` and `issue*_pc` are don't-care while invalid; the bench checks them only when valid.
- Reset asserted mid-operation discards all contents immediately.
- Push-to-issue latency is 1 cycle: an entry pushed at edge N is visible on `issue*` after edge N.
- Issue outputs and `pair_ok` are combinational from queue state. Decode samples them at the same edge that pops.
- Full queue: `fetch_ready=0`, and `fetch_valid` is ignored with no overflow.
- Empty queue: no pop, and `count` never underflows.
- With `issue_stall=1`, outputs hold stable and pushes continue while space remains.

## Configuration

- `ISSUE_DUAL_EN` defined: dual issue as described.
- Not defined:
  - `issue1_valid` is constant 0; at most one instruction pops per cycle.
  - Pairing logic is removed.
  - `issue1_inst` and `issue1_pc` still mirror head+1.

## Test plan

All scenarios use `DEPTH=8`.

- Reset, then push `fetch_pc=0x0` with {0x00200113, 0x00100093} (addi x1; addi x2), `issue_stall=0` → next cycle both valid, PCs 0x0/0x4; after next edge count=0.
- Push addi x1,x0,1 (0x00100093) plus add x3,x1,x1 (0x001081B3) → cycle 1 `issue1_valid=0`; cycle 2 slot 0 = 0x001081B3, PC 0x4.
- Push beq (0x00000063) plus addi → single issue; two lw (0x0000A083, 0x0000A103) → single issue.
- `fetch_pc=0x104` → count=1, `issue0_pc=0x104`, `issue0_inst=fetch_inst[63:32]`.
- `issue_stall=1`, push four pairs → count=8, `fetch_ready=0`; a fifth pair is ignored. Then `flush` → count=0 and all valids low after the edge.
- `ISSUE_DUAL_EN` undefined, two independent addis → issued on consecutive cycles, `issue1_valid` always 0.
